// File: rtl/dac_channel_arbiter.sv
// dac_channel_arbiter: round-robin arbiter feeding N_CHAN channel codes into
// one serial DAC. Each channel keeps its latest code in a holding register
// with a pending flag; the FSM grants pending channels in round-robin order
// and shifts a 32-bit frame {4'h0, control, address, code, 4'h0} out MSB first.
// Optional feature macro: DAC_ARB_LDAC_EN. When defined, frames only write the
// DAC input registers, and one nLDAC pulse updates all outputs together once
// no channel is pending.
module dac_channel_arbiter #(
    parameter int N_CHAN   = 8,
    parameter int SCLK_DIV = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [N_CHAN*16-1:0]  data_in,
    input  logic [N_CHAN-1:0]     data_valid_in,
    output logic                  dac_nsync_out,
    output logic                  dac_sclk_out,
    output logic                  dac_din_out,
    output logic                  dac_nldac_out,
    output logic                  busy_out,
    output logic [3:0]            grant_out
);

    localparam int IW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int DW = $clog2(2 * SCLK_DIV) + 1;
    localparam logic [DW-1:0] C_HALF_LAST = DW'(SCLK_DIV - 1);
    localparam logic [DW-1:0] C_GAP_LAST  = DW'(2 * SCLK_DIV - 1);
`ifdef DAC_ARB_LDAC_EN
    localparam logic [3:0] C_CTRL = 4'h0;   // write input register only
`else
    localparam logic [3:0] C_CTRL = 4'h3;   // write and update output
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
`ifdef DAC_ARB_LDAC_EN
        S_GAP   = 3'd3,
        S_LDAC  = 3'd4
`else
        S_GAP   = 3'd3
`endif
    } state_t;

    state_t       r_state, w_state_next;
    logic         r_nsync, w_nsync_next;
    logic         r_sclk,  w_sclk_next;
    logic         r_din,   w_din_next;
    logic         r_nldac, w_nldac_next;
    logic [3:0]   r_grant, w_grant_next;
    logic [DW-1:0] r_div,  w_div_next;
    logic [4:0]   r_bit,   w_bit_next;
    logic [31:0]  r_shift, w_shift_next;
    logic [15:0]  r_code,  w_code_next;

    logic [N_CHAN-1:0] w_flag;
    logic [15:0]       w_hold [N_CHAN];
    logic              w_any;
    logic              w_grant_fire;
    logic [3:0]        w_sel;
    logic [15:0]       w_sel_code;

    assign w_any        = |w_flag;
    assign w_grant_fire = (r_state == S_IDLE) && w_any;

    // Per-channel holding register and pending flag. A strobe always wins over
    // the grant-clear, so a strobe landing in its own grant cycle stays pending.
    genvar gi;
    generate
        for (gi = 0; gi < N_CHAN; gi++) begin : g_chan
            logic [15:0] r_hold;
            logic        r_flag;

            // Capture the latest code; clear the flag when this channel is granted.
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    r_hold <= '0;
                    r_flag <= 1'b0;
                end else if (data_valid_in[gi]) begin
                    r_hold <= data_in[16*gi +: 16];
                    r_flag <= 1'b1;
                end else if (w_grant_fire && (w_sel == 4'(gi))) begin
                    r_flag <= 1'b0;
                end
            end

            assign w_flag[gi] = r_flag;
            assign w_hold[gi] = r_hold;
        end
    endgenerate

    // Round-robin pick: scan offsets from farthest to nearest so that the
    // nearest pending channel after the last grant is the final assignment.
    always_comb begin
        int             v_pos;
        logic [IW-1:0]  v_idx;
        v_pos      = 0;
        v_idx      = '0;
        w_sel      = r_grant;
        w_sel_code = '0;
        for (int i = N_CHAN; i >= 1; i--) begin
            v_pos = int'(r_grant) + i;
            if (v_pos >= N_CHAN) begin
                v_pos = v_pos - N_CHAN;
            end
            v_idx = IW'(v_pos);
            if (w_flag[v_idx]) begin
                w_sel      = 4'(v_pos);
                w_sel_code = w_hold[v_idx];
            end
        end
    end

    // FSM state and registered serial outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
            r_nsync <= 1'b1;
            r_sclk  <= 1'b1;
            r_din   <= 1'b0;
            r_nldac <= 1'b1;
            r_grant <= 4'(N_CHAN - 1);
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_code  <= '0;
        end else begin
            r_state <= w_state_next;
            r_nsync <= w_nsync_next;
            r_sclk  <= w_sclk_next;
            r_din   <= w_din_next;
            r_nldac <= w_nldac_next;
            r_grant <= w_grant_next;
            r_div   <= w_div_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_code  <= w_code_next;
        end
    end

    // Next-state and output logic. The code is latched at grant time so a
    // strobe in the grant cycle cannot alter the frame already granted.
    always_comb begin
        w_state_next = r_state;
        w_nsync_next = r_nsync;
        w_sclk_next  = r_sclk;
        w_din_next   = r_din;
        w_nldac_next = r_nldac;
        w_grant_next = r_grant;
        w_div_next   = r_div;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_code_next  = r_code;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_next = w_sel;
                    w_code_next  = w_sel_code;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_shift_next = {4'h0, C_CTRL, r_grant, r_code, 4'h0};
                w_din_next   = 1'b0;           // frame bit 31 is always zero
                w_nsync_next = 1'b0;
                w_sclk_next  = 1'b1;
                w_div_next   = '0;
                w_bit_next   = '0;
                w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_div == C_HALF_LAST) begin
                    w_div_next = '0;
                    if (r_sclk) begin
                        w_sclk_next = 1'b0;
                    end else if (r_bit == 5'd31) begin
                        w_sclk_next  = 1'b1;
                        w_nsync_next = 1'b1;
                        w_din_next   = 1'b0;
                        w_state_next = S_GAP;
                    end else begin
                        // Next bit goes out together with the rising edge.
                        w_sclk_next  = 1'b1;
                        w_bit_next   = r_bit + 5'd1;
                        w_din_next   = r_shift[30];
                        w_shift_next = r_shift << 1;
                    end
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            S_GAP: begin
                if (r_div == C_GAP_LAST) begin
                    w_div_next   = '0;
                    w_state_next = S_IDLE;
`ifdef DAC_ARB_LDAC_EN
                    if (!w_any) begin
                        w_state_next = S_LDAC;
                        w_nldac_next = 1'b0;
                    end
`endif
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
`ifdef DAC_ARB_LDAC_EN
            S_LDAC: begin
                if (r_div == C_GAP_LAST) begin
                    w_div_next   = '0;
                    w_nldac_next = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign dac_nsync_out = r_nsync;
    assign dac_sclk_out  = r_sclk;
    assign dac_din_out   = r_din;
    assign dac_nldac_out = r_nldac;
    assign busy_out      = (r_state != S_IDLE);
    assign grant_out     = r_grant;

endmodule

// File: tb/tb_dac_channel_arbiter.sv
// tb_dac_channel_arbiter: directed vectors for dac_channel_arbiter with
// N_CHAN=8, SCLK_DIV=2. Honours DAC_ARB_LDAC_EN when the build defines it.
module tb_dac_channel_arbiter;

    localparam int N_CHAN   = 8;
    localparam int SCLK_DIV = 2;

    logic                 clk_in = 1'b0;
    logic                 rst_n_in;
    logic [N_CHAN*16-1:0] data_in;
    logic [N_CHAN-1:0]    data_valid_in;
    logic                 dac_nsync_out;
    logic                 dac_sclk_out;
    logic                 dac_din_out;
    logic                 dac_nldac_out;
    logic                 busy_out;
    logic [3:0]           grant_out;

    int n_vec = 0;
    int n_bad = 0;

    dac_channel_arbiter #(.N_CHAN(N_CHAN), .SCLK_DIV(SCLK_DIV)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .data_in       (data_in),
        .data_valid_in (data_valid_in),
        .dac_nsync_out (dac_nsync_out),
        .dac_sclk_out  (dac_sclk_out),
        .dac_din_out   (dac_din_out),
        .dac_nldac_out (dac_nldac_out),
        .busy_out      (busy_out),
        .grant_out     (grant_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          ch;
        logic [15:0] code;
        logic [31:0] frame;
        logic [3:0]  grant;
    } vec_t;

    vec_t vecs [5];

    // Expected frames are written for control 4'h3; the LDAC build uses 4'h0.
    function automatic logic [31:0] ctl(input logic [31:0] f);
`ifdef DAC_ARB_LDAC_EN
        return f & 32'hF0FF_FFFF;
`else
        return f;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic strobe(input int ca, input logic [15:0] da, input int cb, input logic [15:0] db);
        @(posedge clk_in); #1;
        data_in[16*ca +: 16] = da;
        data_valid_in[ca]    = 1'b1;
        if (cb >= 0) begin
            data_in[16*cb +: 16] = db;
            data_valid_in[cb]    = 1'b1;
        end
        @(posedge clk_in); #1;
        data_valid_in = '0;
        $display("strobe ch%0d=%h%s", ca, da, (cb >= 0) ? $sformatf(" ch%0d=%h", cb, db) : "");
    endtask

    // Samples just after each rising clk edge. Returns latency (edges until
    // nsync is seen low), nsync-low length, bits taken on sclk falling edges,
    // whether sclk was high when nsync rose, and nldac-low samples seen.
    task automatic capture(output logic [31:0] fr, output int lat, output int lowc,
                           output int nb, output logic rise_ok, output int nl);
        logic prev;
        fr = '0; lat = -1; lowc = 0; nb = 0; rise_ok = 1'b0; nl = 0;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk_in); #1;
            if (!dac_nldac_out) nl++;
            if (!dac_nsync_out) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            $display("frame timeout");
            return;
        end
        prev = dac_sclk_out;
        lowc = 1;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk_in); #1;
            if (!dac_nldac_out) nl++;
            if (dac_nsync_out) begin
                rise_ok = dac_sclk_out;
                break;
            end
            lowc++;
            if (prev && !dac_sclk_out) begin
                fr = {fr[30:0], dac_din_out};
                nb++;
            end
            prev = dac_sclk_out;
        end
        $display("frame %h grant=%0d lat=%0d low=%0d bits=%0d", fr, grant_out, lat, lowc, nb);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 1000; k++) begin
            @(posedge clk_in); #1;
            if (!busy_out) break;
        end
        chk("idle_timeout", 32'(k >= 1000), 32'd0);
    endtask

    task automatic watch_quiet(input string nm, input int cycles);
        int lows = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk_in); #1;
            if (!dac_nsync_out) lows++;
        end
        chk(nm, 32'(lows), 32'd0);
    endtask

    initial begin
        logic [31:0] fr;
        int          lat, lowc, nb, nl, falls;
        logic        rise_ok, prev;

        vecs[0] = '{0, 16'h9999, 32'h0309_9990, 4'd0};
        vecs[1] = '{3, 16'hABCD, 32'h033A_BCD0, 4'd3};
        vecs[2] = '{7, 16'hFFFF, 32'h037F_FFF0, 4'd7};
        vecs[3] = '{1, 16'h0001, 32'h0310_0010, 4'd1};
        vecs[4] = '{3, 16'h8000, 32'h0338_0000, 4'd3};

        rst_n_in      = 1'b0;
        data_in       = '0;
        data_valid_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_nsync", 32'(dac_nsync_out), 32'd1);
        chk("rst_sclk",  32'(dac_sclk_out),  32'd1);
        chk("rst_din",   32'(dac_din_out),   32'd0);
        chk("rst_nldac", 32'(dac_nldac_out), 32'd1);
        chk("rst_busy",  32'(busy_out),      32'd0);
        chk("rst_grant", 32'(grant_out),     32'd7);
        #2 rst_n_in = 1'b1;
        watch_quiet("no_frame_after_reset", 20);

        // Single-channel frames from idle.
        for (int v = 0; v < 5; v++) begin
            strobe(vecs[v].ch, vecs[v].code, -1, 16'h0);
            capture(fr, lat, lowc, nb, rise_ok, nl);
            chk($sformatf("v%0d_frame", v),   fr, ctl(vecs[v].frame));
            chk($sformatf("v%0d_latency", v), 32'(lat), 32'd2);
            chk($sformatf("v%0d_nsync_len", v), 32'(lowc), 32'(64 * SCLK_DIV));
            chk($sformatf("v%0d_bits", v),    32'(nb), 32'd32);
            chk($sformatf("v%0d_sclk_rise", v), 32'(rise_ok), 32'd1);
            chk($sformatf("v%0d_grant", v),   32'(grant_out), 32'(vecs[v].grant));
            chk($sformatf("v%0d_nldac_high", v), 32'(nl), 32'd0);
            wait_idle();
        end

        // Two strobes in one cycle with grant_out=3: ch5 first, then ch2.
        strobe(2, 16'h1234, 5, 16'hCCCC);
        capture(fr, lat, lowc, nb, rise_ok, nl);
        chk("rr_first_frame", fr, ctl(32'h035C_CCC0));
        chk("rr_first_grant", 32'(grant_out), 32'd5);
        capture(fr, lat, lowc, nb, rise_ok, nl);
        chk("rr_second_frame", fr, ctl(32'h0321_2340));
        chk("rr_second_grant", 32'(grant_out), 32'd2);
        wait_idle();

        // Two ch1 strobes during a ch0 frame collapse into one ch1 frame.
        fork
            begin
                strobe(0, 16'h5A5A, -1, 16'h0);
                capture(fr, lat, lowc, nb, rise_ok, nl);
            end
            begin
                repeat (20) @(posedge clk_in);
                strobe(1, 16'h1111, -1, 16'h0);
                repeat (30) @(posedge clk_in);
                strobe(1, 16'h2222, -1, 16'h0);
            end
        join
        chk("lw_ch0_frame", fr, ctl(32'h0305_A5A0));
        capture(fr, lat, lowc, nb, rise_ok, nl);
        chk("lw_ch1_frame", fr, ctl(32'h0312_2220));
        chk("lw_ch1_grant", 32'(grant_out), 32'd1);
        watch_quiet("lw_single_ch1_frame", 400);

        // ch6 strobed at its flag-setting edge and again in its grant cycle.
        @(posedge clk_in); #1;
        data_in[16*6 +: 16] = 16'h6666;
        data_valid_in[6]    = 1'b1;
        @(posedge clk_in); #1;
        data_in[16*6 +: 16] = 16'h7777;
        @(posedge clk_in); #1;
        data_valid_in = '0;
        $display("strobe ch6=6666 then ch6=7777 in grant cycle");
        capture(fr, lat, lowc, nb, rise_ok, nl);
        chk("gc_old_frame", fr, ctl(32'h0366_6660));
        capture(fr, lat, lowc, nb, rise_ok, nl);
        chk("gc_new_frame", fr, ctl(32'h0367_7770));
        chk("gc_grant", 32'(grant_out), 32'd6);
        wait_idle();

`ifdef DAC_ARB_LDAC_EN
        // Two frames back to back, then a single 2*SCLK_DIV nLDAC pulse.
        begin
            int nlow = 0;
            int pulses = 0;
            logic pn = 1'b1;
            strobe(0, 16'h0AAA, 1, 16'h0BBB);
            capture(fr, lat, lowc, nb, rise_ok, nl);
            chk("ld_ch0_frame", fr, 32'h0000_AAA0);
            capture(fr, lat, lowc, nb, rise_ok, nl);
            chk("ld_ch1_frame", fr, 32'h0010_BBB0);
            chk("ld_nldac_between", 32'(nl), 32'd0);
            for (int k = 0; k < 40; k++) begin
                @(posedge clk_in); #1;
                if (!dac_nldac_out) nlow++;
                if (pn && !dac_nldac_out) pulses++;
                pn = dac_nldac_out;
            end
            chk("ld_pulse_count", 32'(pulses), 32'd1);
            chk("ld_pulse_width", 32'(nlow), 32'(2 * SCLK_DIV));
            wait_idle();
        end
`endif

        // Asynchronous reset at bit 10 of a ch0 frame with ch4 pending.
        strobe(0, 16'h0F0F, -1, 16'h0);
        strobe(4, 16'h4444, -1, 16'h0);
        falls = 0;
        prev  = dac_sclk_out;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk_in); #1;
            if (prev && !dac_sclk_out) falls++;
            prev = dac_sclk_out;
            if (falls == 10) break;
        end
        chk("ar_reached_bit10", 32'(falls), 32'd10);
        chk("ar_nsync_before", 32'(dac_nsync_out), 32'd0);
        #2 rst_n_in = 1'b0;
        #1;
        $display("reset asserted mid-frame");
        chk("ar_nsync", 32'(dac_nsync_out), 32'd1);
        chk("ar_sclk",  32'(dac_sclk_out),  32'd1);
        chk("ar_din",   32'(dac_din_out),   32'd0);
        chk("ar_busy",  32'(busy_out),      32'd0);
        chk("ar_grant", 32'(grant_out),     32'd7);
        @(posedge clk_in); #3;
        rst_n_in = 1'b1;
        watch_quiet("ar_no_frame_after_release", 500);
        chk("ar_busy_after", 32'(busy_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
